// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, source ids and result type for the register write-back unit
package wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_SRC = 3;
  localparam int STARVE_LIMIT = 4;
  typedef enum logic [1:0] {SRC_LSU, SRC_ALU, SRC_MULDIV} wb_src_e;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_result_t;
endpackage

// File: rtl/wb_arbiter.sv
// wb_arbiter: fixed-priority one-hot grant with promotion of sources starved for STARVE_LIMIT cycles
module wb_arbiter #(
  parameter int NUM_SRC = wb_pkg::NUM_SRC,
  parameter int STARVE_LIMIT = wb_pkg::STARVE_LIMIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant
);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  logic [WAIT_W-1:0] wait_cnt [NUM_SRC];
  logic [NUM_SRC-1:0] promo, pool;
  // starved requesters form the candidate pool when present; lowest index of the pool wins
  always_comb begin
    promo = '0;
    for (int s = 0; s < NUM_SRC; s++) promo[s] = req[s] && wait_cnt[s] == WAIT_W'(STARVE_LIMIT);
    pool = |promo ? promo : req;
    grant = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--) if (pool[s]) grant = NUM_SRC'(1) << s;
  end
  // count cycles a held result loses, saturating at the promotion threshold
  always_ff @(posedge clk)
    for (int s = 0; s < NUM_SRC; s++)
      if (reset || !req[s] || grant[s]) wait_cnt[s] <= '0;
      else if (wait_cnt[s] != WAIT_W'(STARVE_LIMIT)) wait_cnt[s] <= wait_cnt[s] + WAIT_W'(1);
endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: arbitrates producer results onto the register file write port and tracks pending destinations
module reg_writeback_unit #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int NUM_SRC = wb_pkg::NUM_SRC,
  parameter int STARVE_LIMIT = wb_pkg::STARVE_LIMIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_rd,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      iss_valid,
  input  logic [ADDR_W-1:0]         iss_rd,
  output logic                      iss_conflict,
  output logic [2**ADDR_W-1:0]      busy,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      write_en
);
  logic [NUM_SRC-1:0] hold_v, req, grant, xfer;
  logic [ADDR_W-1:0] hold_rd [NUM_SRC];
  logic [DATA_W-1:0] hold_data [NUM_SRC];
  logic [2**ADDR_W-1:0] busy_n;
  logic iss_set, waw_ok;
  assign req = reset ? '0 : hold_v;
  assign src_ready = reset ? '0 : ~hold_v | grant;
  assign xfer = src_valid & src_ready;
  assign write_en = |grant;
  assign iss_conflict = iss_valid & busy[iss_rd];
  assign iss_set = iss_valid && iss_rd != '0 && !iss_conflict;
  wb_arbiter #(.NUM_SRC(NUM_SRC), .STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(req),
    .grant(grant)
  );
  // hold entries: a transfer on the grant edge refills the slot; rd 0 results are dropped
  always_ff @(posedge clk)
    for (int s = 0; s < NUM_SRC; s++) begin
      if (reset) hold_v[s] <= 1'b0;
      else if (xfer[s]) hold_v[s] <= src_rd[s*ADDR_W +: ADDR_W] != '0;
      else if (grant[s]) hold_v[s] <= 1'b0;
      if (xfer[s]) begin
        hold_rd[s] <= src_rd[s*ADDR_W +: ADDR_W];
        hold_data[s] <= src_data[s*DATA_W +: DATA_W];
      end
    end
  // write port mux: the one-hot grant selects the entry, zero when idle
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int s = 0; s < NUM_SRC; s++)
      if (grant[s]) begin
        wr_addr = hold_rd[s];
        wr_data = hold_data[s];
      end
  end
  // scoreboard next state: a new issue to the index being written keeps it busy
  always_comb begin
    busy_n = busy;
    if (write_en) busy_n[wr_addr] = 1'b0;
    if (iss_set) busy_n[iss_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end
  // scoreboard register
  always_ff @(posedge clk) busy <= reset ? '0 : busy_n;
  // two live hold entries must never target the same register
  always_comb begin
    waw_ok = 1'b1;
    for (int i = 0; i < NUM_SRC; i++)
      for (int j = i + 1; j < NUM_SRC; j++)
        if (hold_v[i] && hold_v[j] && hold_rd[i] == hold_rd[j]) waw_ok = 1'b0;
  end
  a_waw: assert property (@(posedge clk) disable iff (reset) waw_ok);
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed table, corner sequences and randomized run against a behavioural model
module tb_reg_writeback_unit;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] src_valid, src_ready;
  logic [14:0] src_rd;
  logic [95:0] src_data;
  logic iss_valid, iss_conflict, write_en;
  logic [4:0] iss_rd, wr_addr;
  logic [31:0] busy, wr_data;

  always #5 clk = ~clk;

  reg_writeback_unit dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_data(src_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_conflict(iss_conflict), .busy(busy), .wr_addr(wr_addr), .wr_data(wr_data),
    .write_en(write_en)
  );

  typedef struct {
    logic rst; logic [2:0] vld; logic [14:0] rd; logic [95:0] data; logic iv; logic [4:0] ir;
    logic we; logic [4:0] wa; logic [31:0] wd; logic [2:0] rdy; logic cf; logic [31:0] bz;
  } vec_t;

  int n_cmp = 0, n_err = 0;
  bit m_hv [3];
  logic [4:0] m_rd [3];
  logic [31:0] m_data [3];
  int m_wait [3];
  logic [31:0] m_busy = '0;
  logic obs_we;
  logic [4:0] obs_wa;
  logic [31:0] obs_busy;
  vec_t tab [24];
  vec_t nov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // model: starved held results first (lowest index), otherwise lowest held index
  function automatic int m_grant();
    if (reset) return -1;
    for (int s = 0; s < 3; s++) if (m_hv[s] && m_wait[s] >= LIM) return s;
    for (int s = 0; s < 3; s++) if (m_hv[s]) return s;
    return -1;
  endfunction

  task automatic m_update(input int g, input logic [2:0] rdy, input logic cf);
    if (reset) begin
      for (int s = 0; s < 3; s++) begin m_hv[s] = 0; m_wait[s] = 0; end
      m_busy = '0;
    end else begin
      if (g >= 0) m_busy[m_rd[g]] = 1'b0;
      if (iss_valid && iss_rd != 0 && !cf) m_busy[iss_rd] = 1'b1;
      m_busy[0] = 1'b0;
      for (int s = 0; s < 3; s++) begin
        if (g == s) begin m_hv[s] = 0; m_wait[s] = 0; end
        else if (m_hv[s]) m_wait[s] = m_wait[s] < LIM ? m_wait[s] + 1 : LIM;
        else m_wait[s] = 0;
        if (src_valid[s] && rdy[s]) begin
          m_hv[s] = src_rd[s*5 +: 5] != 0;
          m_rd[s] = src_rd[s*5 +: 5];
          m_data[s] = src_data[s*32 +: 32];
        end
      end
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; src_valid = v.vld; src_rd = v.rd; src_data = v.data;
    iss_valid = v.iv; iss_rd = v.ir;
  endtask

  // one clock: check outputs mid-cycle against the table row or the model, then advance the model
  task automatic step(input bit use_tab, input vec_t v, input string tag);
    int g;
    logic [2:0] erdy;
    logic ecf, ewe;
    logic [4:0] ewa;
    logic [31:0] ewd, ebz;
    @(negedge clk);
    g = m_grant();
    for (int s = 0; s < 3; s++) erdy[s] = !reset && (!m_hv[s] || g == s);
    ecf = iss_valid && m_busy[iss_rd];
    ewe = g >= 0; ewa = '0; ewd = '0; ebz = m_busy;
    if (g >= 0) begin ewa = m_rd[g]; ewd = m_data[g]; end
    if (use_tab) begin ewe = v.we; ewa = v.wa; ewd = v.wd; erdy = v.rdy; ecf = v.cf; ebz = v.bz; end
    obs_we = write_en; obs_wa = wr_addr; obs_busy = busy;
    chk({tag, "_write_en"}, {31'd0, write_en}, {31'd0, ewe});
    chk({tag, "_wr_addr"}, {27'd0, wr_addr}, {27'd0, ewa});
    chk({tag, "_wr_data"}, wr_data, ewd);
    chk({tag, "_src_ready"}, {29'd0, src_ready}, {29'd0, erdy});
    chk({tag, "_iss_conflict"}, {31'd0, iss_conflict}, {31'd0, ecf});
    chk({tag, "_busy"}, busy, ebz);
    @(posedge clk);
    m_update(g, src_ready, iss_conflict);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic [2:0] vld, input logic [14:0] rd,
                              input logic [95:0] data, input logic iv, input logic [4:0] ir,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [2:0] rdy, input logic cf, input logic [31:0] bz);
    vec_t v;
    v.rst = rst; v.vld = vld; v.rd = rd; v.data = data; v.iv = iv; v.ir = ir;
    v.we = we; v.wa = wa; v.wd = wd; v.rdy = rdy; v.cf = cf; v.bz = bz;
    return v;
  endfunction

  initial begin
    int held;
    bit done;
    logic [31:0] b5 = 32'h20, b7 = 32'h80;
    logic [95:0] d0 = '0;
    nov = mk(1'b0, 3'b0, 15'd0, d0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 3'b0, 1'b0, 32'd0);
    tab[0]  = mk(1'b1, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 3'b000, 1'b0, 32'd0);
    tab[1]  = mk(1'b0, 3'b000, 15'd0, d0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, 32'd0);
    tab[2]  = mk(1'b0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 1'b0, 5'd0,
                 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, b5);
    tab[3]  = mk(1'b0, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 3'b111, 1'b0, b5);
    tab[4]  = mk(1'b0, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, 32'd0);
    tab[5]  = mk(1'b0, 3'b011, {5'd0, 5'd4, 5'd3}, {32'd0, 32'h44, 32'h33}, 1'b0, 5'd0,
                 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, 32'd0);
    tab[6]  = mk(1'b0, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 3'b101, 1'b0, 32'd0);
    tab[7]  = mk(1'b0, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h44, 3'b111, 1'b0, 32'd0);
    tab[8]  = mk(1'b0, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, 32'd0);
    tab[9]  = mk(1'b0, 3'b010, 15'd0, {32'd0, 32'h99, 32'd0}, 1'b0, 5'd0,
                 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, 32'd0);
    tab[10] = mk(1'b0, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, 32'd0);
    tab[11] = mk(1'b0, 3'b000, 15'd0, d0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, 32'd0);
    tab[12] = mk(1'b0, 3'b000, 15'd0, d0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 3'b111, 1'b1, b7);
    tab[13] = mk(1'b0, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, b7);
    tab[14] = mk(1'b0, 3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h77, 32'd0}, 1'b0, 5'd0,
                 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, b7);
    tab[15] = mk(1'b0, 3'b000, 15'd0, d0, 1'b1, 5'd7, 1'b1, 5'd7, 32'h77, 3'b111, 1'b1, b7);
    tab[16] = mk(1'b0, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, 32'd0);
    tab[17] = mk(1'b0, 3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h70, 32'd0}, 1'b0, 5'd0,
                 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, 32'd0);
    tab[18] = mk(1'b0, 3'b000, 15'd0, d0, 1'b1, 5'd7, 1'b1, 5'd7, 32'h70, 3'b111, 1'b0, 32'd0);
    tab[19] = mk(1'b0, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, b7);
    tab[20] = mk(1'b0, 3'b000, 15'd0, d0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 3'b111, 1'b1, b7);
    tab[21] = mk(1'b0, 3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h71, 32'd0}, 1'b0, 5'd0,
                 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, b7);
    tab[22] = mk(1'b0, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h71, 3'b111, 1'b0, b7);
    tab[23] = mk(1'b0, 3'b000, 15'd0, d0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 3'b111, 1'b0, 32'd0);

    drive(tab[0]);
    @(posedge clk); #1;
    for (int i = 0; i < 24; i++) begin
      drive(tab[i]);
      step(1'b1, tab[i], $sformatf("row%0d", i));
    end

    // MULDIV arrives one cycle ahead of a continuous LSU/ALU stream
    drive(nov);
    src_valid = 3'b101; src_rd = {5'd25, 5'd0, 5'd1}; src_data = {32'hD00D, 32'd0, 32'h1};
    step(1'b0, nov, "starve_in");
    held = 0; done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      src_valid = 3'b011;
      src_rd = {5'd0, 5'd20, 5'(1 + i % 8)};
      src_data = {32'd0, 32'hA000 + 32'(i), 32'hB000 + 32'(i)};
      step(1'b0, nov, "starve");
      held++;
      if (obs_we && obs_wa == 5'd25) done = 1;
    end
    chk("starve_latency", {31'd0, done && held <= 5}, 32'd1);
    drive(nov);
    for (int i = 0; i < 6; i++) step(1'b0, nov, "drain");

    // reset with all three holds occupied
    src_valid = 3'b111; src_rd = {5'd13, 5'd12, 5'd11}; src_data = {32'hC3, 32'hC2, 32'hC1};
    iss_valid = 1'b1; iss_rd = 5'd9;
    step(1'b0, nov, "fill");
    drive(nov); reset = 1'b1;
    step(1'b0, nov, "rst");
    chk("rst_write_en", {31'd0, obs_we}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, nov, "post_rst");
      chk("post_rst_write_en", {31'd0, obs_we}, 32'd0);
      chk("post_rst_busy", obs_busy, 32'd0);
    end

    // randomized traffic, producers drawing destinations from disjoint pools
    for (int n = 0; n < 1500; n++) begin
      reset = $urandom_range(0, 199) == 0;
      src_valid = 3'($urandom);
      for (int s = 0; s < 3; s++) begin
        src_rd[s*5 +: 5] = $urandom_range(0, 7) == 0 ? 5'd0 : 5'(1 + 10 * s + $urandom_range(0, 9));
        src_data[s*32 +: 32] = $urandom;
      end
      iss_valid = 1'($urandom);
      iss_rd = 5'($urandom_range(0, 31));
      step(1'b0, nov, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
